// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic feed path.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } feed_state_e;

   // Advance count at which the last result row of a tile leaves the array bottom.
   function automatic int unsigned calc_t_end(input int unsigned k,
                                              input int unsigned length,
                                              input int unsigned array_lat);
      return k + length + array_lat - 1;
   endfunction

endpackage

// File: rtl/systolic_perf_counter.sv
// Saturating 32-bit event counter with synchronous clear.
module systolic_perf_counter (
   input  logic        CLK,
   input  logic        SYNC_RST,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         count <= 32'd0;
      end else if (inc && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/systolic_feed_controller.sv
// Feeds one tile of activation vectors through the skew buffer into the PE array.
// Optional performance counters are built when SYSTOLIC_FEED_PERF_CNT_EN is defined.
module systolic_feed_controller
   import systolic_pkg::*;
#(
   parameter int unsigned LENGTH    = 256,
   parameter int unsigned K_MAX     = 1024,
   parameter int unsigned ARRAY_LAT = 2,
   parameter int unsigned K_W       = $clog2(K_MAX + 1),
   parameter int unsigned T_W       = $clog2(K_MAX + LENGTH + ARRAY_LAT + 1)
) (
   input  logic           CLK,
   input  logic           SYNC_RST,
   input  logic           start_i,
   input  logic [K_W-1:0] k_len_i,
   input  logic           stall_i,
   output logic           busy_o,
   output logic           done_o,
   output logic           rd_en_o,
   output logic [K_W-1:0] rd_addr_o,
   output logic           setup_en_o,
   output logic           setup_clr_o,
   output logic           feed_zero_o,
   output logic           acc_valid_o,
   output logic           acc_last_o
`ifdef SYSTOLIC_FEED_PERF_CNT_EN
   ,
   output logic [31:0]    perf_busy_cyc_o,
   output logic [31:0]    perf_stall_cyc_o
`endif
);

   localparam logic [T_W-1:0] T_ACC0 = T_W'(LENGTH + ARRAY_LAT);

   feed_state_e    state_q, state_d;
   logic [K_W-1:0] k_q, k_d;
   logic [T_W-1:0] t_q, t_d;
   logic [T_W-1:0] k_t;
   logic [T_W-1:0] t_end;

   assign k_t   = T_W'(k_q);
   assign t_end = T_W'(calc_t_end(32'(k_q), LENGTH, ARRAY_LAT));

   // State, tile length and advance counter.
   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         state_q <= IDLE;
         k_q     <= '0;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         t_q     <= t_d;
      end
   end

   // Next state and output decode; stall gates RUN outputs combinationally.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      t_d         = t_q;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      rd_en_o     = 1'b0;
      rd_addr_o   = '0;
      setup_en_o  = 1'b0;
      setup_clr_o = 1'b0;
      feed_zero_o = 1'b0;
      acc_valid_o = 1'b0;
      acc_last_o  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (k_len_i != '0) begin
                  k_d     = k_len_i;
                  t_d     = '0;
                  state_d = CLEAR;
               end else begin
                  state_d = DONE;
               end
            end
         end
         CLEAR: begin
            busy_o      = 1'b1;
            setup_clr_o = 1'b1;
            state_d     = RUN;
         end
         RUN: begin
            busy_o = 1'b1;
            if (!stall_i) begin
               rd_en_o     = (t_q < k_t);
               rd_addr_o   = (t_q < k_t) ? K_W'(t_q) : '0;
               setup_en_o  = (t_q != '0);
               feed_zero_o = (t_q > k_t);
               acc_valid_o = (t_q >= T_ACC0) && (t_q <= t_end);
               acc_last_o  = (t_q == t_end);
               t_d         = t_q + T_W'(1);
               if (t_q == t_end) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef SYSTOLIC_FEED_PERF_CNT_EN
   logic run_stall;

   assign run_stall = (state_q == RUN) && stall_i;

   systolic_perf_counter u_perf_busy (
      .CLK      (CLK),
      .SYNC_RST (SYNC_RST),
      .inc      (busy_o),
      .count    (perf_busy_cyc_o)
   );

   systolic_perf_counter u_perf_stall (
      .CLK      (CLK),
      .SYNC_RST (SYNC_RST),
      .inc      (run_stall),
      .count    (perf_stall_cyc_o)
   );
`endif

endmodule

// File: tb/tb_systolic_feed_controller.sv
// Directed bench for systolic_feed_controller with LENGTH=4, ARRAY_LAT=2.
module tb_systolic_feed_controller;

   localparam int unsigned LENGTH    = 4;
   localparam int unsigned ARRAY_LAT = 2;
   localparam int unsigned K_MAX     = 1024;
   localparam int unsigned K_W       = $clog2(K_MAX + 1);

   logic           CLK;
   logic           SYNC_RST;
   logic           start_i;
   logic [K_W-1:0] k_len_i;
   logic           stall_i;
   logic           busy_o;
   logic           done_o;
   logic           rd_en_o;
   logic [K_W-1:0] rd_addr_o;
   logic           setup_en_o;
   logic           setup_clr_o;
   logic           feed_zero_o;
   logic           acc_valid_o;
   logic           acc_last_o;
`ifdef SYSTOLIC_FEED_PERF_CNT_EN
   logic [31:0]    perf_busy_cyc_o;
   logic [31:0]    perf_stall_cyc_o;
`endif

   int checks = 0;
   int errors = 0;

   systolic_feed_controller #(
      .LENGTH    (LENGTH),
      .K_MAX     (K_MAX),
      .ARRAY_LAT (ARRAY_LAT)
   ) dut (
      .CLK         (CLK),
      .SYNC_RST    (SYNC_RST),
      .start_i     (start_i),
      .k_len_i     (k_len_i),
      .stall_i     (stall_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .rd_en_o     (rd_en_o),
      .rd_addr_o   (rd_addr_o),
      .setup_en_o  (setup_en_o),
      .setup_clr_o (setup_clr_o),
      .feed_zero_o (feed_zero_o),
      .acc_valid_o (acc_valid_o),
      .acc_last_o  (acc_last_o)
`ifdef SYSTOLIC_FEED_PERF_CNT_EN
      ,
      .perf_busy_cyc_o  (perf_busy_cyc_o),
      .perf_stall_cyc_o (perf_stall_cyc_o)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic win(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   // Hand-derived windows; flags = {busy, done, clr, rd, sen, fz, av, al}.
   function automatic logic [7:0] exp_flags(input int scn, input int c);
      logic busy, done, clr, rd, sen, fz, av, al;
      int m;
      {busy, done, clr, rd, sen, fz, av, al} = 8'h00;
      m = c % 10;
      case (scn)
         1, 4: begin
            if (scn == 1 || c <= 6) begin
               busy = win(c, 1, 11);
               done = (c == 11);
               clr  = (c == 1);
               rd   = win(c, 2, 4);
               sen  = win(c, 3, 10);
               fz   = win(c, 6, 10);
               av   = win(c, 8, 10);
               al   = (c == 10);
            end
         end
         2: begin
            busy = win(c, 1, 13);
            done = (c == 13);
            clr  = (c == 1);
            rd   = (c == 2) || win(c, 5, 6);
            sen  = win(c, 5, 12);
            fz   = win(c, 8, 12);
            av   = win(c, 10, 12);
            al   = (c == 12);
         end
         3: begin
            busy = (c == 1);
            done = (c == 1);
         end
         5: begin
            busy = (m != 0);
            done = (m == 9);
            clr  = (m == 1);
            rd   = (m == 2);
            sen  = win(m, 3, 8);
            fz   = win(m, 4, 8);
            av   = (m == 8);
            al   = (m == 8);
         end
         default: ;
      endcase
      return {busy, done, clr, rd, sen, fz, av, al};
   endfunction

   function automatic logic [K_W-1:0] exp_addr(input int scn, input int c);
      logic [K_W-1:0] a;
      a = '0;
      if (scn == 1 || scn == 4) begin
         if (c == 3) a = K_W'(1);
         if (c == 4) a = K_W'(2);
      end else if (scn == 2) begin
         if (c == 5) a = K_W'(1);
         if (c == 6) a = K_W'(2);
      end
      return a;
   endfunction

   task automatic run_scn(input int scn, input int k, input int ncyc);
      logic [7:0] f;
      int nav;
      nav = 0;
      @(negedge CLK);
      start_i = 1'b1;
      k_len_i = K_W'(k);
      @(posedge CLK);
      for (int c = 1; c <= ncyc; c++) begin
         #1;
         if (scn != 5) start_i = 1'b0;
         stall_i  = (scn == 2) && (c >= 3) && (c <= 4);
         SYNC_RST = (scn == 4) && (c == 6);
         @(negedge CLK);
         f = {busy_o, done_o, setup_clr_o, rd_en_o, setup_en_o, feed_zero_o,
              acc_valid_o, acc_last_o};
         chk($sformatf("s%0d c%0d flags", scn, c), 32'(f), 32'(exp_flags(scn, c)));
         chk($sformatf("s%0d c%0d addr", scn, c), 32'(rd_addr_o), 32'(exp_addr(scn, c)));
         if (acc_valid_o) nav++;
         if (c < ncyc) @(posedge CLK);
      end
      start_i  = 1'b0;
      stall_i  = 1'b0;
      SYNC_RST = 1'b0;
      if (scn == 5) chk("s5 acc_valid count", 32'(nav), 32'd3);
      repeat (2) @(posedge CLK);
   endtask

   initial begin
      SYNC_RST = 1'b1;
      start_i  = 1'b0;
      k_len_i  = '0;
      stall_i  = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset flags", 32'({busy_o, done_o, setup_clr_o, rd_en_o, setup_en_o,
                              feed_zero_o, acc_valid_o, acc_last_o}), 32'd0);
      chk("reset addr", 32'(rd_addr_o), 32'd0);
      SYNC_RST = 1'b0;
      repeat (2) @(posedge CLK);

      run_scn(2, 3, 14);
`ifdef SYSTOLIC_FEED_PERF_CNT_EN
      chk("perf busy", perf_busy_cyc_o, 32'd13);
      chk("perf stall", perf_stall_cyc_o, 32'd2);
`endif
      run_scn(1, 3, 12);
      run_scn(3, 0, 3);
      run_scn(4, 3, 12);
      run_scn(1, 3, 12);
      run_scn(5, 1, 30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
